// File: rtl/instruction_fetch_if.sv
// Fetch-stage buses: instruction-memory request/response port and the decode hand-off.
interface instruction_fetch_if #(
   parameter int ADDR_W  = 16,
   parameter int INSTR_W = 24
) ();
   logic               imem_req_valid;
   logic [ADDR_W-1:0]  imem_req_addr;
   logic               imem_req_ready;
   logic               imem_rsp_valid;
   logic [INSTR_W-1:0] imem_rsp_data;
   logic               id_valid;
   logic               id_ready;
   logic [INSTR_W-1:0] id_instr;
   logic [ADDR_W-1:0]  id_pc;
   logic [3:0]         id_opcode;

   modport master (
      output imem_req_valid, imem_req_addr,
      input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
      output id_valid, id_instr, id_pc, id_opcode,
      input  id_ready
   );

   modport slave (
      input  imem_req_valid, imem_req_addr,
      output imem_req_ready, imem_rsp_valid, imem_rsp_data,
      input  id_valid, id_instr, id_pc, id_opcode,
      output id_ready
   );
endinterface

// File: rtl/instruction_fetch.sv
// Fetch stage: owns the PC, issues word reads, buffers in-order responses in a
// 2-entry FIFO for decode and flushes wrong-path work on a branch redirect.
module instruction_fetch #(
   parameter int                ADDR_W   = 16,
   parameter int                INSTR_W  = 24,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic                Clock,
   input  logic                Reset_n,
   instruction_fetch_if.master bus,
   input  logic                Redirect,
   input  logic [ADDR_W-1:0]   RedirectPC
);

   logic               run_q;
   logic [ADDR_W-1:0]  pc_q, pc_d;
   logic [1:0]         out_cnt_q, out_cnt_d;
   logic [1:0]         drop_cnt_q, drop_cnt_d;
   logic [1:0]         fifo_cnt_q, fifo_cnt_d;
   logic               oq_wr_q, oq_rd_q;
   logic               f_wr_q, f_wr_d;
   logic               f_rd_q, f_rd_d;
   logic [ADDR_W-1:0]  oq_pc_q   [2];
   logic [ADDR_W-1:0]  f_pc_q    [2];
   logic [INSTR_W-1:0] f_instr_q [2];

   logic               fifo_nz;
   logic               id_valid_w;
   logic               pop;
   logic               req_valid;
   logic               accept;
   logic               rsp;
   logic               keep;
   logic [2:0]         occupancy;
   logic [2:0]         room;
   logic [INSTR_W-1:0] head_instr;
   logic [ADDR_W-1:0]  head_pc;

   assign fifo_nz    = (fifo_cnt_q != 2'd0);
   assign id_valid_w = fifo_nz && !Redirect;
   assign pop        = id_valid_w && bus.id_ready;

   // A slot freed by this cycle's pop may be reused by this cycle's request.
   assign occupancy = {1'b0, out_cnt_q} + {1'b0, fifo_cnt_q};
   assign room      = 3'd2 + {2'b00, pop};
   assign req_valid = run_q && !Redirect && (occupancy < room);
   assign accept    = req_valid && bus.imem_req_ready;
   assign rsp       = bus.imem_rsp_valid;
   assign keep      = rsp && !Redirect && (drop_cnt_q == 2'd0);

   always_comb begin
      pc_d       = pc_q;
      out_cnt_d  = out_cnt_q + 2'(accept) - 2'(rsp);
      drop_cnt_d = drop_cnt_q;
      fifo_cnt_d = fifo_cnt_q;
      f_wr_d     = f_wr_q;
      f_rd_d     = f_rd_q;
      if (Redirect) begin
         // Every request still owed a response becomes stale, including the one arriving now.
         pc_d       = RedirectPC;
         drop_cnt_d = out_cnt_d;
         fifo_cnt_d = 2'd0;
         f_wr_d     = 1'b0;
         f_rd_d     = 1'b0;
      end else begin
         if (accept) pc_d = pc_q + ADDR_W'(1);
         if (rsp && (drop_cnt_q != 2'd0)) drop_cnt_d = drop_cnt_q - 2'd1;
         fifo_cnt_d = fifo_cnt_q + 2'(keep) - 2'(pop);
         if (keep) f_wr_d = ~f_wr_q;
         if (pop)  f_rd_d = ~f_rd_q;
      end
   end

   always_ff @(posedge Clock or negedge Reset_n) begin
      if (!Reset_n) begin
         run_q      <= 1'b0;
         pc_q       <= RESET_PC;
         out_cnt_q  <= 2'd0;
         drop_cnt_q <= 2'd0;
         fifo_cnt_q <= 2'd0;
         oq_wr_q    <= 1'b0;
         oq_rd_q    <= 1'b0;
         f_wr_q     <= 1'b0;
         f_rd_q     <= 1'b0;
      end else begin
         run_q      <= 1'b1;
         pc_q       <= pc_d;
         out_cnt_q  <= out_cnt_d;
         drop_cnt_q <= drop_cnt_d;
         fifo_cnt_q <= fifo_cnt_d;
         f_wr_q     <= f_wr_d;
         f_rd_q     <= f_rd_d;
         // Stale responses still retire their outstanding-PC entry.
         if (accept) oq_wr_q <= ~oq_wr_q;
         if (rsp)    oq_rd_q <= ~oq_rd_q;
      end
   end

   always_ff @(posedge Clock) begin
      if (accept) oq_pc_q[oq_wr_q] <= pc_q;
      if (keep) begin
         f_pc_q[f_wr_q]    <= oq_pc_q[oq_rd_q];
         f_instr_q[f_wr_q] <= bus.imem_rsp_data;
      end
   end

   assign head_instr = fifo_nz ? f_instr_q[f_rd_q] : '0;
   assign head_pc    = fifo_nz ? f_pc_q[f_rd_q]    : '0;

   assign bus.imem_req_valid = req_valid;
   assign bus.imem_req_addr  = pc_q;
   assign bus.id_valid       = id_valid_w;
   assign bus.id_instr       = head_instr;
   assign bus.id_pc          = head_pc;
   assign bus.id_opcode      = head_instr[INSTR_W-1 -: 4];

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: memory model, program-order scoreboard, directed and random phases.
module tb_instruction_fetch;
   localparam logic [15:0] RESET_PC = 16'h0000;

   typedef struct packed {
      logic [15:0] pc;
      logic [23:0] instr;
   } sb_t;

   logic        Clock = 1'b0;
   logic        Reset_n;
   logic        Redirect;
   logic [15:0] RedirectPC;
   logic        Redirect2;
   logic [15:0] RedirectPC2;

   int  n_checks = 0;
   int  n_fail   = 0;
   sb_t sb_q[$];

   logic        mem_rand      = 1'b0;
   logic        mem_hold      = 1'b0;
   logic        mem_ready_off = 1'b0;
   logic [15:0] mq[$];
   logic [15:0] exp_req;

   int          wrap_n;
   logic        wrap_pc_seen;
   logic [15:0] wrap_exp [4] = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001};

   instruction_fetch_if #(.ADDR_W(16), .INSTR_W(24)) bus  ();
   instruction_fetch_if #(.ADDR_W(16), .INSTR_W(24)) bus2 ();

   instruction_fetch #(.ADDR_W(16), .INSTR_W(24), .RESET_PC(RESET_PC)) u_dut (
      .Clock      (Clock),
      .Reset_n    (Reset_n),
      .bus        (bus),
      .Redirect   (Redirect),
      .RedirectPC (RedirectPC)
   );

   instruction_fetch #(.ADDR_W(16), .INSTR_W(24), .RESET_PC(16'hFFFE)) u_wrap (
      .Clock      (Clock),
      .Reset_n    (Reset_n),
      .bus        (bus2),
      .Redirect   (Redirect2),
      .RedirectPC (RedirectPC2)
   );

   always #5 Clock = ~Clock;

   // Memory contents: opcode nibble varies with the upper address bits.
   function automatic logic [23:0] mem_data(input logic [15:0] a);
      return {a[15:12] ^ 4'h1, 4'h0, a};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Program-order reference: from a start PC, instructions arrive at consecutive addresses.
   task automatic sb_restart(input logic [15:0] start);
      logic [15:0] p;
      p = start;
      sb_q.delete();
      for (int i = 0; i < 512; i++) begin
         sb_q.push_back({p, mem_data(p)});
         p = p + 16'd1;
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_req_valid"}, bus.imem_req_valid, 0);
      chk({tag, "_req_addr"},  bus.imem_req_addr,  RESET_PC);
      chk({tag, "_id_valid"},  bus.id_valid,       0);
      chk({tag, "_id_instr"},  bus.id_instr,       0);
      chk({tag, "_id_pc"},     bus.id_pc,          0);
      chk({tag, "_id_opcode"}, bus.id_opcode,      0);
   endtask

   // Instruction memory: in-order responses, at least one cycle after acceptance.
   initial begin
      logic        acc, took;
      logic [15:0] a;
      bus.imem_req_ready = 1'b1;
      bus.imem_rsp_valid = 1'b0;
      bus.imem_rsp_data  = '0;
      exp_req            = RESET_PC;
      forever begin
         @(negedge Clock);
         acc  = bus.imem_req_valid && bus.imem_req_ready;
         took = bus.imem_rsp_valid;
         a    = bus.imem_req_addr;
         if (!Reset_n) exp_req = RESET_PC;
         else if (Redirect) begin
            chk("req_valid_in_redirect", bus.imem_req_valid, 0);
            exp_req = RedirectPC;
         end else if (acc) begin
            chk("req_addr_sequence", a, exp_req);
            exp_req = exp_req + 16'd1;
         end
         @(posedge Clock);
         #1;
         if (!Reset_n) begin
            mq.delete();
            bus.imem_rsp_valid = 1'b0;
         end else begin
            if (took && mq.size() > 0) void'(mq.pop_front());
            if (acc) mq.push_back(a);
            if (mq.size() > 0 && !mem_hold && (!mem_rand || $urandom_range(0, 2) != 0)) begin
               bus.imem_rsp_valid = 1'b1;
               bus.imem_rsp_data  = mem_data(mq[0]);
            end else begin
               bus.imem_rsp_valid = 1'b0;
               bus.imem_rsp_data  = 24'($urandom);
            end
         end
         bus.imem_req_ready = mem_rand ? ($urandom_range(0, 3) != 0) : !mem_ready_off;
      end
   end

   // Monitor: scoreboard pops on every decode hand-off; request stability under back-pressure.
   initial begin
      logic        pv_stall;
      logic [15:0] pv_addr;
      sb_t         e;
      pv_stall = 1'b0;
      pv_addr  = '0;
      forever begin
         @(negedge Clock);
         if (!Reset_n) pv_stall = 1'b0;
         else begin
            if (Redirect) chk("id_valid_in_redirect", bus.id_valid, 0);
            else if (pv_stall) begin
               chk("req_addr_held",  bus.imem_req_addr,  pv_addr);
               chk("req_valid_held", bus.imem_req_valid, 1);
            end
            pv_stall = bus.imem_req_valid && !bus.imem_req_ready;
            pv_addr  = bus.imem_req_addr;
            if (bus.id_valid && bus.id_ready) begin
               if (sb_q.size() == 0) begin
                  n_checks++;
                  n_fail++;
                  $display("FAIL sb_underflow: got id_pc %0h, expected no delivery", bus.id_pc);
               end else begin
                  e = sb_q.pop_front();
                  chk("sb_id_pc",     bus.id_pc,     e.pc);
                  chk("sb_id_instr",  bus.id_instr,  e.instr);
                  chk("sb_id_opcode", bus.id_opcode, e.instr[23:20]);
               end
            end
         end
      end
   end

   // Second instance starting near the top of the address space, fed by an always-ready memory.
   initial begin
      logic        acc2;
      logic [15:0] a2;
      Redirect2          = 1'b0;
      RedirectPC2        = '0;
      bus2.imem_req_ready = 1'b1;
      bus2.imem_rsp_valid = 1'b0;
      bus2.imem_rsp_data  = '0;
      bus2.id_ready       = 1'b1;
      wrap_n              = 0;
      wrap_pc_seen        = 1'b0;
      forever begin
         @(negedge Clock);
         acc2 = Reset_n && bus2.imem_req_valid;
         a2   = bus2.imem_req_addr;
         if (acc2 && wrap_n < 4) begin
            chk("wrap_req_addr", a2, wrap_exp[wrap_n]);
            wrap_n++;
         end
         if (Reset_n && bus2.id_valid && !wrap_pc_seen) begin
            chk("wrap_first_id_pc", bus2.id_pc, 16'hFFFE);
            wrap_pc_seen = 1'b1;
         end
         @(posedge Clock);
         #1;
         bus2.imem_rsp_valid = acc2 && Reset_n;
         bus2.imem_rsp_data  = mem_data(a2);
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected test completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int          k;
      int          since;
      logic [15:0] a0;
      Reset_n      = 1'b0;
      Redirect     = 1'b0;
      RedirectPC   = '0;
      bus.id_ready = 1'b1;
      sb_restart(RESET_PC);
      #2;
      check_reset_outputs("por");
      repeat (3) @(posedge Clock);
      #1 Reset_n = 1'b1;

      // Streaming at one instruction per cycle.
      @(negedge Clock);
      chk("valid_before_first_edge", bus.imem_req_valid, 0);
      for (int c = 0; c < 8; c++) begin
         @(negedge Clock);
         chk("p1_req_valid", bus.imem_req_valid, 1);
         chk("p1_req_addr",  bus.imem_req_addr,  32'(c));
         if (c >= 2) begin
            chk("p1_id_valid",  bus.id_valid,  1);
            chk("p1_id_pc",     bus.id_pc,     32'(c - 2));
            chk("p1_id_opcode", bus.id_opcode, 4'h1);
         end
      end

      // Asynchronous reset in the middle of the stream.
      @(posedge Clock);
      #3 Reset_n = 1'b0;
      #1;
      check_reset_outputs("async");
      bus.id_ready = 1'b0;
      sb_restart(RESET_PC);
      repeat (2) @(posedge Clock);
      #1 Reset_n = 1'b1;

      // Decode stall: two entries fill, issue stops.
      k = 0;
      while (!bus.id_valid && k < 20) begin
         @(negedge Clock);
         k++;
      end
      chk("stall_first_valid", bus.id_valid, 1);
      for (int i = 0; i < 5; i++) begin
         if (i > 0) @(negedge Clock);
         chk("stall_id_valid", bus.id_valid, 1);
         chk("stall_id_pc",    bus.id_pc,    0);
         if (i == 4) chk("stall_issue_stopped", bus.imem_req_valid, 0);
      end
      @(posedge Clock);
      #1 bus.id_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge Clock);
         chk("release_id_valid", bus.id_valid, 1);
         chk("release_id_pc",    bus.id_pc,    32'(i));
      end

      // Redirect with two requests outstanding and the memory holding responses.
      @(negedge Clock);
      mem_hold = 1'b1;
      repeat (4) @(negedge Clock);
      chk("hold_no_issue", bus.imem_req_valid, 0);
      @(posedge Clock);
      #1;
      Redirect   = 1'b1;
      RedirectPC = 16'h0040;
      sb_restart(16'h0040);
      @(negedge Clock);
      chk("p3_id_valid_redirect", bus.id_valid, 0);
      mem_hold = 1'b0;
      @(posedge Clock);
      #1 Redirect = 1'b0;
      k = 0;
      while (!(bus.id_valid && bus.id_ready) && k < 20) begin
         @(negedge Clock);
         k++;
      end
      chk("p3_target_delivered", bus.id_valid, 1);
      chk("p3_target_pc",        bus.id_pc,    16'h0040);

      // Redirect coinciding with a response in steady streaming.
      repeat (4) @(negedge Clock);
      @(posedge Clock);
      #1;
      Redirect   = 1'b1;
      RedirectPC = 16'h1234;
      sb_restart(16'h1234);
      @(posedge Clock);
      #1 Redirect = 1'b0;
      @(negedge Clock);
      chk("p4_req_valid_n1", bus.imem_req_valid, 1);
      chk("p4_req_addr_n1",  bus.imem_req_addr,  16'h1234);
      @(negedge Clock);
      @(negedge Clock);
      chk("p4_id_valid_n3", bus.id_valid, 1);
      chk("p4_id_pc_n3",    bus.id_pc,    16'h1234);

      // Memory back-pressure: address held for three cycles.
      @(negedge Clock);
      mem_ready_off = 1'b1;
      @(negedge Clock);
      a0 = bus.imem_req_addr;
      chk("p5_valid0", bus.imem_req_valid, 1);
      for (int i = 0; i < 2; i++) begin
         @(negedge Clock);
         chk("p5_valid", bus.imem_req_valid, 1);
         chk("p5_addr",  bus.imem_req_addr,  a0);
      end
      mem_ready_off = 1'b0;

      // Randomized memory timing, decode stalls and redirects.
      @(negedge Clock);
      mem_rand = 1'b1;
      since    = 0;
      for (int cyc = 0; cyc < 1500; cyc++) begin
         @(posedge Clock);
         #1;
         bus.id_ready = ($urandom_range(0, 3) != 0);
         if (Redirect) Redirect = 1'b0;
         else if ($urandom_range(0, 29) == 0 || since > 200) begin
            Redirect   = 1'b1;
            RedirectPC = 16'($urandom);
            sb_restart(RedirectPC);
            since = 0;
         end else since++;
      end
      @(posedge Clock);
      #1 Redirect = 1'b0;
      @(negedge Clock);
      mem_rand = 1'b0;
      repeat (10) @(negedge Clock);

      chk("wrap_req_count", wrap_n, 4);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
